// File: rtl/stf_sync_detect.sv
// STF sync detector: lag-16 delayed autocorrelation and window power,
// with a plateau counter that raises a sticky short-preamble flag.
module stf_sync_detect #(
  parameter int LAG   = 16,
  parameter int WIN   = 16,
  parameter int CNT_W = 8,
  parameter int IDX_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [31:0]      sample_in,
  input  logic             sample_in_strobe,
  input  logic [39:0]      power_floor,
  input  logic [CNT_W-1:0] min_plateau,
  output logic             short_preamble_detected,
  output logic [IDX_W-1:0] detect_index,
  output logic [CNT_W-1:0] plateau_count,
  output logic             metric_strobe
);

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    SEARCH   = 2'd1,
    DETECTED = 2'd2
  } state_t;

  state_t state, nstate;

  logic signed [15:0] si, sq, di, dq;
  logic [31:0]        dly [LAG];
  logic signed [31:0] m_ii, m_qq, m_qi, m_iq, m_i2, m_q2;
  logic signed [32:0] re_c, im_c;
  logic [32:0]        pw_c;

  logic signed [32:0] p_re, p_im;
  logic [32:0]        p_pw;
  logic               s1_v;
  logic [IDX_W-1:0]   s1_idx, idx;

  logic signed [32:0] hr [WIN];
  logic signed [32:0] hi [WIN];
  logic [32:0]        hp [WIN];
  logic signed [36:0] cr, ci;
  logic [36:0]        pp;
  logic               s2_v;
  logic [IDX_W-1:0]   s2_idx;

  logic signed [39:0] cr40, ci40;
  logic [39:0]        acr, aci, lhs, rhs;
  logic               hit;
  logic [CNT_W-1:0]   tgt, inc, cnt_nxt;
  logic               ld_idx;

  assign si = sample_in[31:16];
  assign sq = sample_in[15:0];
  assign di = dly[LAG-1][31:16];
  assign dq = dly[LAG-1][15:0];

  assign m_ii = 32'(si) * 32'(di);
  assign m_qq = 32'(sq) * 32'(dq);
  assign m_qi = 32'(sq) * 32'(di);
  assign m_iq = 32'(si) * 32'(dq);
  assign m_i2 = 32'(si) * 32'(si);
  assign m_q2 = 32'(sq) * 32'(sq);

  assign re_c = 33'(m_ii) + 33'(m_qq);
  assign im_c = 33'(m_qi) - 33'(m_iq);
  assign pw_c = 33'(m_i2) + 33'(m_q2);

  // S1: delay line and products, advanced on strobe only
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAG; i++) dly[i] <= '0;
      p_re   <= '0;
      p_im   <= '0;
      p_pw   <= '0;
      s1_v   <= 1'b0;
      s1_idx <= '0;
      idx    <= '0;
    end else if (!enable) begin
      for (int i = 0; i < LAG; i++) dly[i] <= '0;
      p_re   <= '0;
      p_im   <= '0;
      p_pw   <= '0;
      s1_v   <= 1'b0;
      s1_idx <= '0;
      idx    <= '0;
    end else begin
      s1_v <= sample_in_strobe;
      if (sample_in_strobe) begin
        dly[0] <= sample_in;
        for (int i = 1; i < LAG; i++) dly[i] <= dly[i-1];
        p_re   <= re_c;
        p_im   <= im_c;
        p_pw   <= pw_c;
        s1_idx <= idx;
        if (idx != '1) idx <= idx + IDX_W'(1);
      end
    end
  end

  // S2: running window sums; history supplies the value leaving the window
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIN; i++) begin
        hr[i] <= '0;
        hi[i] <= '0;
        hp[i] <= '0;
      end
      cr     <= '0;
      ci     <= '0;
      pp     <= '0;
      s2_v   <= 1'b0;
      s2_idx <= '0;
    end else if (!enable) begin
      for (int i = 0; i < WIN; i++) begin
        hr[i] <= '0;
        hi[i] <= '0;
        hp[i] <= '0;
      end
      cr     <= '0;
      ci     <= '0;
      pp     <= '0;
      s2_v   <= 1'b0;
      s2_idx <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        cr    <= cr + 37'(p_re) - 37'(hr[WIN-1]);
        ci    <= ci + 37'(p_im) - 37'(hi[WIN-1]);
        pp    <= pp + 37'(p_pw) - 37'(hp[WIN-1]);
        hr[0] <= p_re;
        hi[0] <= p_im;
        hp[0] <= p_pw;
        for (int i = 1; i < WIN; i++) begin
          hr[i] <= hr[i-1];
          hi[i] <= hi[i-1];
          hp[i] <= hp[i-1];
        end
        s2_idx <= s1_idx;
      end
    end
  end

  assign metric_strobe = s2_v;

  // S3: 4(|Cr|+|Ci|) >= 3P at 40 bits, cannot overflow
  assign cr40 = 40'(cr);
  assign ci40 = 40'(ci);
  assign acr  = cr40[39] ? -cr40 : cr40;
  assign aci  = ci40[39] ? -ci40 : ci40;
  assign lhs  = (acr + aci) << 2;
  assign rhs  = 40'(pp) + (40'(pp) << 1);
  assign hit  = (40'(pp) >= power_floor) && (lhs >= rhs);

  assign tgt = (min_plateau == '0) ? CNT_W'(1) : min_plateau;
  assign inc = (plateau_count == '1) ? plateau_count
                                     : plateau_count + CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        state <= FILL;
    else if (!enable) state <= FILL;
    else              state <= nstate;
  end

  always_comb begin
    nstate  = state;
    cnt_nxt = plateau_count;
    ld_idx  = 1'b0;
    unique case (1'b1)
      (state == FILL): begin
        if (s2_v && s2_idx == IDX_W'(LAG + WIN - 2)) nstate = SEARCH;
      end
      (state == SEARCH): begin
        if (s2_v) begin
          if (hit) begin
            cnt_nxt = inc;
            if (inc >= tgt) begin
              nstate = DETECTED;
              ld_idx = 1'b1;
            end
          end else begin
            cnt_nxt = '0;
          end
        end
      end
      (state == DETECTED): begin
        nstate = DETECTED;
      end
      default: nstate = FILL;
    endcase
  end

  always_comb begin
    short_preamble_detected = (state == DETECTED);
  end

  // detect_index survives enable low; only reset clears it
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      plateau_count <= '0;
      detect_index  <= '0;
    end else if (!enable) begin
      plateau_count <= '0;
    end else begin
      plateau_count <= cnt_nxt;
      if (ld_idx) detect_index <= s2_idx;
    end
  end

endmodule

// File: tb/tb_stf_sync_detect.sv
// Directed bench for stf_sync_detect: STF plateau, zeros, sign flips,
// min_plateau 0, enable drop and mid-plateau reset.
module tb_stf_sync_detect;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] sample_in;
  logic        sample_in_strobe;
  logic [39:0] power_floor;
  logic [7:0]  min_plateau;
  logic        short_preamble_detected;
  logic [15:0] detect_index;
  logic [7:0]  plateau_count;
  logic        metric_strobe;

  int checks = 0;
  int errors = 0;

  stf_sync_detect dut (
    .clock                   (clock),
    .reset                   (reset),
    .enable                  (enable),
    .sample_in               (sample_in),
    .sample_in_strobe        (sample_in_strobe),
    .power_floor             (power_floor),
    .min_plateau             (min_plateau),
    .short_preamble_detected (short_preamble_detected),
    .detect_index            (detect_index),
    .plateau_count           (plateau_count),
    .metric_strobe           (metric_strobe)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // I=Q=+-754 with a fixed 16-periodic sign pattern; optional Q flip
  function automatic logic [31:0] stf(input int k, input bit flipq);
    logic [15:0] pat;
    logic [15:0] v, q;
    pat = 16'b1011001011010001;
    v   = pat[k[3:0]] ? 16'h02f2 : 16'hfd0e;
    q   = flipq ? -v : v;
    return {v, q};
  endfunction

  task automatic put(input logic [31:0] s, input logic v);
    @(negedge clock);
    sample_in        = s;
    sample_in_strobe = v;
  endtask

  task automatic settle();
    repeat (3) put(32'h0, 1'b0);
  endtask

  task automatic run_stf(input int lo, input int hi, input bit flipq);
    for (int k = lo; k <= hi; k++) put(stf(k, flipq), 1'b1);
  endtask

  task automatic cycle_enable();
    enable = 1'b0;
    put(32'h0, 1'b0);
    enable = 1'b1;
  endtask

  initial begin
    reset            = 1'b1;
    enable           = 1'b0;
    sample_in        = '0;
    sample_in_strobe = 1'b0;
    power_floor      = 40'd1000;
    min_plateau      = 8'd64;
    #1;
    chk("rst_flag", int'(short_preamble_detected), 0);
    chk("rst_didx", int'(detect_index), 0);
    chk("rst_cnt", int'(plateau_count), 0);
    chk("rst_ms", int'(metric_strobe), 0);
    @(negedge clock);
    reset  = 1'b0;
    enable = 1'b1;

    // STF, min_plateau 64: first hit 31, detect at 94
    put(stf(0, 0), 1'b1);
    put(32'h0, 1'b0);
    chk("ms_d1", int'(metric_strobe), 0);
    put(32'h0, 1'b0);
    chk("ms_d2", int'(metric_strobe), 1);
    put(32'h0, 1'b0);
    chk("ms_d3", int'(metric_strobe), 0);
    run_stf(1, 30, 0);
    put(stf(31, 0), 1'b1);
    put(32'h0, 1'b0);
    put(32'h0, 1'b0);
    chk("hit31_early", int'(plateau_count), 0);
    put(32'h0, 1'b0);
    chk("hit31", int'(plateau_count), 1);
    run_stf(32, 93, 0);
    put(stf(94, 0), 1'b1);
    put(32'h0, 1'b0);
    put(32'h0, 1'b0);
    chk("det94_early", int'(short_preamble_detected), 0);
    chk("cnt93", int'(plateau_count), 63);
    put(32'h0, 1'b0);
    chk("det94_flag", int'(short_preamble_detected), 1);
    chk("det94_idx", int'(detect_index), 94);
    chk("det94_cnt", int'(plateau_count), 64);

    // enable drop two cycles after detection, then zeros
    put(32'h0, 1'b0);
    put(32'h0, 1'b0);
    enable = 1'b0;
    put(32'h0, 1'b0);
    chk("en_lo_flag", int'(short_preamble_detected), 0);
    chk("en_lo_didx", int'(detect_index), 94);
    chk("en_lo_cnt", int'(plateau_count), 0);
    enable      = 1'b1;
    power_floor = 40'd1;
    for (int k = 0; k < 200; k++) begin
      put(32'h0, 1'b1);
      if (k % 50 == 49) begin
        chk("zero_cnt", int'(plateau_count), 0);
        chk("zero_flag", int'(short_preamble_detected), 0);
      end
    end
    settle();
    chk("zero_cnt_end", int'(plateau_count), 0);
    chk("zero_didx", int'(detect_index), 94);

    // min_plateau 0: detect on first SEARCH hit; index restarted at 0
    cycle_enable();
    power_floor = 40'd1000;
    min_plateau = 8'd0;
    run_stf(0, 31, 0);
    put(32'h0, 1'b0);
    put(32'h0, 1'b0);
    chk("mp0_early", int'(short_preamble_detected), 0);
    put(32'h0, 1'b0);
    chk("mp0_flag", int'(short_preamble_detected), 1);
    chk("mp0_didx", int'(detect_index), 31);
    chk("mp0_cnt", int'(plateau_count), 1);
    run_stf(32, 60, 1);
    run_stf(61, 80, 0);
    settle();
    chk("hold_flag", int'(short_preamble_detected), 1);
    chk("hold_didx", int'(detect_index), 31);
    chk("hold_cnt", int'(plateau_count), 1);

    // Q-flip segment 60..75: misses at 78..88, detect at 89+63
    cycle_enable();
    min_plateau = 8'd64;
    run_stf(0, 59, 0);
    run_stf(60, 75, 1);
    run_stf(76, 77, 0);
    settle();
    chk("flip_cnt77", int'(plateau_count), 47);
    run_stf(78, 88, 0);
    settle();
    chk("flip_cnt88", int'(plateau_count), 0);
    put(stf(89, 0), 1'b1);
    settle();
    chk("flip_cnt89", int'(plateau_count), 1);
    run_stf(90, 151, 0);
    settle();
    chk("flip_early", int'(short_preamble_detected), 0);
    chk("flip_cnt151", int'(plateau_count), 63);
    put(stf(152, 0), 1'b1);
    settle();
    chk("flip_flag", int'(short_preamble_detected), 1);
    chk("flip_didx", int'(detect_index), 152);

    // reset mid-plateau with strobes flowing
    cycle_enable();
    run_stf(0, 72, 0);
    @(posedge clock);
    #2;
    chk("pre_rst_cnt", int'(plateau_count), 40);
    chk("pre_rst_ms", int'(metric_strobe), 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_flag", int'(short_preamble_detected), 0);
    chk("mid_rst_cnt", int'(plateau_count), 0);
    chk("mid_rst_didx", int'(detect_index), 0);
    chk("mid_rst_ms", int'(metric_strobe), 0);
    put(32'h0, 1'b0);
    reset = 1'b0;
    run_stf(0, 93, 0);
    settle();
    chk("rerun_early", int'(short_preamble_detected), 0);
    chk("rerun_cnt", int'(plateau_count), 63);
    put(stf(94, 0), 1'b1);
    settle();
    chk("rerun_flag", int'(short_preamble_detected), 1);
    chk("rerun_didx", int'(detect_index), 94);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/stf_sync_detect.md
Name: stf_sync_detect

Overview:
- Receive-side counterpart of the TX short-training-field (STF) generator.
- Takes the baseband sample stream and computes a lag-16 delayed autocorrelation and a signal power, each summed over a 16-sample sliding window.
- Asserts a sticky detect flag once the normalised correlation has stayed on a plateau long enough.
- Sits ahead of the long-preamble/timing sync in the OFDM RX chain.

Parameters:
- LAG, 16, autocorrelation delay in samples (STF period).
- WIN, 16, sliding-window length in samples; must be a power of 2.
- CNT_W, 8, width of the plateau counter and `min_plateau`.
- IDX_W, 16, width of the sample index counter.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  block run; low clears all state except the outputs listed as held.
- sample_in  in  32  [31:16] I, [15:0] Q, signed 16-bit, same packing as the TX STF samples.
- sample_in_strobe  in  1  sample_in valid; may be high every cycle.
- power_floor  in  40  minimum window power for a hit (unsigned).
- min_plateau  in  CNT_W  consecutive hits required; value 0 is treated as 1.
- short_preamble_detected  out  1  sticky detect flag.
- detect_index  out  IDX_W  sample index of the strobe that completed the plateau.
- plateau_count  out  CNT_W  current consecutive-hit count (debug).
- metric_strobe  out  1  pulses when the window sums for a sample are valid.

Behaviour:

Reset (async, reset high):
- Delay line, window sums and counters are zeroed.
- FSM goes to FILL.
- All outputs are 0.

Per-strobe arithmetic (all signed, full precision, no rounding):
- d = sample delayed LAG strobes; 16-entry shift register that advances on strobe only.
- prod_re = I·Id + Q·Qd (33b).
- prod_im = Q·Id − I·Qd (33b).
- pwr = I² + Q² (33b unsigned).
- Window sums Cr, Ci (37b signed) and P (37b unsigned) are updated as sum += new − value from WIN strobes earlier. A separate WIN-deep history of the products supplies the old value.
- hit = (P ≥ power_floor) AND (4·(|Cr|+|Ci|) ≥ 3·P). Compare is done at 40b; no overflow.

Pipeline:
- S1 registers products on the strobe edge.
- S2 updates the sums.
- S3 evaluates hit and the counter.
- metric_strobe is the strobe delayed 2 clocks.
- Counter and flag update exactly 3 clocks after the input strobe.
- Back-to-back strobes are fully supported; no stalls.

sample_index:
- Counts strobes since enable rose; first strobe = 0.
- Saturates at all-ones.

FSM:
- FILL: count strobes. After LAG+WIN strobes, the window is valid: go to SEARCH. No hits are evaluated in FILL.
- SEARCH: on each S3 valid,
  - hit → plateau_count += 1, saturating;
  - miss → plateau_count = 0.
  - When the incremented count reaches max(min_plateau,1): set short_preamble_detected = 1, latch detect_index = index of that sample, go to DETECTED.
- DETECTED:
  - Flag, detect_index and plateau_count are held.
  - Further strobes are ignored apart from the sample_index count.
  - Leave only via enable low or reset.
- enable low (any state), taking effect next clock:
  - FSM returns to FILL; sums, delay line, sample_index and plateau_count are cleared.
  - short_preamble_detected is cleared.
  - detect_index is held.
  - Strobes are ignored while enable is low.
- Reset mid-operation: immediate return to the reset values, regardless of pipeline contents.
- min_plateau or power_floor changed mid-search: the new value applies from the next S3 evaluation.

Test Plan:
1. Reset, enable=1, 160 strobes of the STF pattern (per sample: I=Q=±754, i.e. 0x02f2/0xfd0e packed as the TX STF), power_floor=1000, min_plateau=64 → steady-state Cr=P=18,192,512, Ci=0, first hit at index 31, flag asserts with detect_index=94, 3 clocks after that strobe.
2. 200 strobes of all-zero samples, power_floor=1 → P=0, no hits, plateau_count stays 0, flag stays 0.
3. STF pattern for 60 samples, then 16 samples with the sign of every sample's Q flipped, then STF again, min_plateau=64 → counter resets to 0 during the flipped segment and flag asserts only after 64 new consecutive hits.
4. min_plateau=0, STF input → flag asserts on the first SEARCH hit, detect_index=31.
5. Drop enable 2 cycles after detection, re-raise it, feed zeros → flag is 0, FSM is in FILL, detect_index still holds 94, sample_index restarts at 0.
6. Assert reset during the plateau (count=40) → all outputs are 0 immediately; after release, detection again requires LAG+WIN fill plus a full plateau.
